// File: rtl/pc_ctrl_pkg.sv
// Opcode map, FSM state encoding and default widths shared by the PC control unit files.
package pc_ctrl_pkg;

  localparam int ADDR_W_DEF      = 10;
  localparam int INSTR_W_DEF     = 32;
  localparam int STACK_DEPTH_DEF = 4;

  localparam logic [5:0] OP_JMP  = 6'h10;
  localparam logic [5:0] OP_BZ   = 6'h11;
  localparam logic [5:0] OP_BNEG = 6'h12;
  localparam logic [5:0] OP_CALL = 6'h13;
  localparam logic [5:0] OP_RET  = 6'h14;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_JMP  = 3'd1,
    CMD_BZ   = 3'd2,
    CMD_BNEG = 3'd3,
    CMD_CALL = 3'd4,
    CMD_RET  = 3'd5,
    CMD_HLT  = 3'd6
  } cmd_t;

  // An invalid word, or any opcode outside the map, decodes as NOP.
  function automatic cmd_t decode_op(input logic valid, input logic [5:0] op);
    cmd_t cmd;
    cmd = CMD_NOP;
    if (valid) begin
      case (op)
        OP_JMP:  cmd = CMD_JMP;
        OP_BZ:   cmd = CMD_BZ;
        OP_BNEG: cmd = CMD_BNEG;
        OP_CALL: cmd = CMD_CALL;
        OP_RET:  cmd = CMD_RET;
        OP_HLT:  cmd = CMD_HLT;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Small LIFO of return addresses; the owner never pushes and pops in the same cycle.
module ret_addr_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  count_q;
  logic [PW:0]  count_d;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_idx  = count_q[PW-1:0];
  // When full the low bits wrap to 0, so subtracting 1 still lands on DEPTH-1.
  assign top_idx = count_q[PW-1:0] - PW'(1);
  assign top_o   = mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (push_i && !full_o) begin
      count_d = count_q + (PW+1)'(1);
    end else if (pop_i && !empty_o) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_control_unit.sv
// Decodes the fetched word into PC control strobes; owns ALU flags, the return stack
// and the halt/resume sequencing.
module pc_control_unit
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic               clock,
  input  logic               resetCPU,
  input  logic [ADDR_W-1:0]  programCounter,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic               alu_zero,
  input  logic               alu_negative,
  input  logic               flag_we,
  input  logic               resume,
  output logic               jump,
  output logic               bzero,
  output logic               bnegative,
  output logic [ADDR_W-1:0]  address,
  output logic               zero,
  output logic               negative,
  output logic               HLT,
  output logic               halted,
  output logic               stack_err,
  output state_t             fsm_state
);

  // instr_valid is a pure qualifier with no ready: a word is consumed in the cycle it is
  // presented with instr_valid=1, and there is no back-pressure toward instruction memory.

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
  logic              zero_q, zero_d;
  logic              negative_q, negative_d;
  logic              stack_err_q, stack_err_d;

  cmd_t              cmd;
  logic [ADDR_W-1:0] imm;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;
  logic              unused_instr;

  assign cmd          = decode_op(instr_valid, instruction[INSTR_W-1:INSTR_W-6]);
  assign imm          = instruction[ADDR_W-1:0];
  assign unused_instr = ^instruction[INSTR_W-7:ADDR_W];

  ret_addr_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clock),
    .rst_i   (resetCPU),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (programCounter + ADDR_W'(1)),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    jump        = 1'b0;
    bzero       = 1'b0;
    bnegative   = 1'b0;
    HLT         = 1'b0;
    address     = '0;
    push        = 1'b0;
    pop         = 1'b0;
    state_d     = state_q;
    halt_pc_d   = halt_pc_q;
    stack_err_d = stack_err_q;
    zero_d      = flag_we ? alu_zero     : zero_q;
    negative_d  = flag_we ? alu_negative : negative_q;

    case (state_q)
      ST_RUN: begin
        case (cmd)
          CMD_JMP: begin
            jump    = 1'b1;
            address = imm;
          end
          CMD_BZ: begin
            bzero   = 1'b1;
            address = imm;
          end
          CMD_BNEG: begin
            bnegative = 1'b1;
            address   = imm;
          end
          CMD_CALL: begin
            // A full stack drops the return address but the call itself still jumps.
            jump    = 1'b1;
            address = imm;
            if (stk_full) stack_err_d = 1'b1;
            else          push        = 1'b1;
          end
          CMD_RET: begin
            if (stk_empty) begin
              stack_err_d = 1'b1;
            end else begin
              jump    = 1'b1;
              address = stk_top;
              pop     = 1'b1;
            end
          end
          CMD_HLT: begin
            HLT       = 1'b1;
            halt_pc_d = programCounter;
            state_d   = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_HALT: begin
        HLT = 1'b1;
        if (resume) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        jump    = 1'b1;
        address = halt_pc_q + ADDR_W'(1);
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Nothing reaches the PC or the stack while reset is held.
    if (resetCPU) begin
      jump      = 1'b0;
      bzero     = 1'b0;
      bnegative = 1'b0;
      HLT       = 1'b0;
      address   = '0;
      push      = 1'b0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (resetCPU) begin
      state_q     <= ST_RUN;
      halt_pc_q   <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pc_q   <= halt_pc_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign zero      = zero_q;
  assign negative  = negative_q;
  assign stack_err = stack_err_q;
  assign halted    = (state_q == ST_HALT);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Self-checking bench for pc_control_unit: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_pc_control_unit;
  import pc_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int MODE_RUN = 0, MODE_HALTED = 1, MODE_RESUMING = 2;

  logic          clock = 1'b0;
  logic          resetCPU = 1'b1;
  logic [AW-1:0] programCounter = '0;
  logic [31:0]   instruction = '0;
  logic          instr_valid = 1'b0;
  logic          alu_zero = 1'b0;
  logic          alu_negative = 1'b0;
  logic          flag_we = 1'b0;
  logic          resume = 1'b0;
  logic          jump, bzero, bnegative, zero, negative, HLT, halted, stack_err;
  logic [AW-1:0] address;
  state_t        fsm_state;

  // clock / reset
  always #5 clock = ~clock;

  pc_control_unit dut (
    .clock          (clock),
    .resetCPU       (resetCPU),
    .programCounter (programCounter),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .alu_zero       (alu_zero),
    .alu_negative   (alu_negative),
    .flag_we        (flag_we),
    .resume         (resume),
    .jump           (jump),
    .bzero          (bzero),
    .bnegative      (bnegative),
    .address        (address),
    .zero           (zero),
    .negative       (negative),
    .HLT            (HLT),
    .halted         (halted),
    .stack_err      (stack_err),
    .fsm_state      (fsm_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int            m_mode = MODE_RUN;
  int            m_stack[$];
  logic          m_zero = 1'b0, m_neg = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_halt_pc = '0;
  logic [17:0]   exp_vec;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [AW-1:0] imm);
    logic [15:0] mid;
    mid = 16'($urandom);
    return {op, mid, imm};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {jump, bzero, bnegative, address, HLT, halted, zero, negative, stack_err};
  endfunction

  task automatic model_expect();
    logic j, bz, bn, h;
    logic [AW-1:0] a;
    j = 1'b0; bz = 1'b0; bn = 1'b0; h = 1'b0; a = '0;
    if (!resetCPU) begin
      if (m_mode == MODE_RESUMING) begin
        j = 1'b1;
        a = m_halt_pc + AW'(1);
      end else if (m_mode == MODE_HALTED) begin
        h = 1'b1;
      end else if (instr_valid) begin
        case (instruction[31:26])
          6'h10: begin j = 1'b1; a = instruction[AW-1:0]; end
          6'h11: begin bz = 1'b1; a = instruction[AW-1:0]; end
          6'h12: begin bn = 1'b1; a = instruction[AW-1:0]; end
          6'h13: begin j = 1'b1; a = instruction[AW-1:0]; end
          6'h14: if (m_stack.size() > 0) begin j = 1'b1; a = AW'(m_stack[$]); end
          6'h3F: h = 1'b1;
          default: ;
        endcase
      end
    end
    exp_vec = {j, bz, bn, a, h, (m_mode == MODE_HALTED), m_zero, m_neg, m_err};
  endtask

  task automatic model_update();
    if (resetCPU) begin
      m_mode = MODE_RUN;
      m_stack.delete();
      m_zero = 1'b0; m_neg = 1'b0; m_err = 1'b0; m_halt_pc = '0;
      return;
    end
    if (flag_we) begin
      m_zero = alu_zero;
      m_neg  = alu_negative;
    end
    case (m_mode)
      MODE_RESUMING: m_mode = MODE_RUN;
      MODE_HALTED:   if (resume) m_mode = MODE_RESUMING;
      default: if (instr_valid) begin
        case (instruction[31:26])
          6'h13: if (m_stack.size() < 4) m_stack.push_back((int'(programCounter) + 1) % 1024);
                 else m_err = 1'b1;
          6'h14: if (m_stack.size() > 0) void'(m_stack.pop_back());
                 else m_err = 1'b1;
          6'h3F: begin m_halt_pc = programCounter; m_mode = MODE_HALTED; end
          default: ;
        endcase
      end
    endcase
  endtask

  // driver: retire the inputs of the previous cycle into the model, apply new inputs
  // at the falling edge, then compute what the DUT should show before the next rise.
  task automatic drive(input logic rst, input logic vld, input logic [31:0] ins,
                       input logic [AW-1:0] pc, input logic fwe, input logic az,
                       input logic an, input logic res);
    model_update();
    @(negedge clock);
    resetCPU = rst; instr_valid = vld; instruction = ins; programCounter = pc;
    flag_we = fwe; alu_zero = az; alu_negative = an; resume = res;
    #1;
    model_expect();
  endtask

  task automatic idle(input logic [AW-1:0] pc);
    drive(1'b0, 1'b0, 32'h0, pc, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, mk(6'h10, 10'h155), 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({jump, bzero, bnegative, HLT, address} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_cycle_outputs: got %h, expected 0", {jump, bzero, bnegative, HLT, address});
    end
    drive(1'b0, 1'b0, mk(6'h10, 10'h155), 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (dut_vec() !== 18'h0 || dut_vec() !== exp_vec) begin
      tests_failed++;
      $display("FAIL reset_state_invalid_word: got %h, expected %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_jmp();
    drive(1'b0, 1'b1, mk(6'h10, 10'h050), 10'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({jump, bzero, bnegative, HLT, address} !== {4'b1000, 10'h050} || dut_vec() !== exp_vec) begin
      tests_failed++;
      $display("FAIL jmp: got %h, expected %h", dut_vec(), exp_vec);
    end
    drive(1'b0, 1'b1, mk(6'h12, 10'h3A7), 10'h101, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({jump, bzero, bnegative, address} !== {3'b001, 10'h3A7}) begin
      tests_failed++;
      $display("FAIL bneg: got %h, expected %h", {jump, bzero, bnegative, address}, {3'b001, 10'h3A7});
    end
  endtask

  task automatic test_flags_bz();
    drive(1'b0, 1'b0, 32'h0, 10'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL flag_not_yet_visible: got %b, expected 0", zero);
    end
    drive(1'b0, 1'b1, mk(6'h11, 10'h004), 10'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({zero, bzero, jump, address} !== {3'b110, 10'h004} || dut_vec() !== exp_vec) begin
      tests_failed++;
      $display("FAIL bz_after_flag: got %h, expected %h", dut_vec(), exp_vec);
    end
    drive(1'b0, 1'b1, mk(6'h11, 10'h007), 10'h12, 1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({zero, bzero} !== 2'b11) begin
      tests_failed++;
      $display("FAIL bz_same_cycle_old_flag: got %b, expected 11", {zero, bzero});
    end
    idle(10'h13);
    tests_run++;
    if ({zero, negative} !== 2'b01 || dut_vec() !== exp_vec) begin
      tests_failed++;
      $display("FAIL flag_update: got %h, expected %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_call_ret();
    drive(1'b1, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, mk(6'h13, 10'h020), 10'h105, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({jump, address} !== {1'b1, 10'h020}) begin
      tests_failed++;
      $display("FAIL call: got %h, expected %h", {jump, address}, {1'b1, 10'h020});
    end
    drive(1'b0, 1'b1, mk(6'h14, 10'h000), 10'h022, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({jump, address} !== {1'b1, 10'h106} || dut_vec() !== exp_vec) begin
      tests_failed++;
      $display("FAIL ret: got %h, expected %h", dut_vec(), exp_vec);
    end
    drive(1'b0, 1'b1, mk(6'h14, 10'h3FF), 10'h106, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({jump, address, stack_err} !== 12'h0) begin
      tests_failed++;
      $display("FAIL ret_on_empty: got %h, expected 0", {jump, address, stack_err});
    end
    idle(10'h107);
    tests_run++;
    if (stack_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_err: got %b, expected 1", stack_err);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] pc;
    drive(1'b1, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pc = AW'($urandom_range(0, 1023));
      if (i < 4) exp_q.push_back(pc + AW'(1));
      drive(1'b0, 1'b1, mk(6'h13, 10'h0A0 + AW'(i)), pc, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if ({jump, address, stack_err} !== {1'b1, 10'h0A0 + AW'(i), 1'b0}) begin
        tests_failed++;
        $display("FAIL call_%0d: got %h, expected %h", i, {jump, address, stack_err}, {1'b1, 10'h0A0 + AW'(i), 1'b0});
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, mk(6'h14, 10'h0), 10'h2C0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (i < 4) begin
        if ({jump, address, stack_err} !== {1'b1, exp_q[$], 1'b1}) begin
          tests_failed++;
          $display("FAIL lifo_ret_%0d: got %h, expected %h", i, {jump, address, stack_err}, {1'b1, exp_q[$], 1'b1});
        end
        void'(exp_q.pop_back());
      end else if ({jump, address} !== 11'h0 || dut_vec() !== exp_vec) begin
        tests_failed++;
        $display("FAIL fifth_ret: got %h, expected %h", dut_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, mk(6'h3F, 10'h0), 10'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({HLT, halted, jump} !== 3'b100) begin
      tests_failed++;
      $display("FAIL hlt_issue: got %b, expected 100", {HLT, halted, jump});
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'($urandom), mk(6'h10 + 6'($urandom_range(0, 4)), 10'($urandom)),
            10'h1FF, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      tests_run++;
      if ({HLT, halted, jump, bzero, bnegative, address} !== {5'b11000, 10'h0} ||
          fsm_state != ST_HALT || dut_vec() !== exp_vec) begin
        tests_failed++;
        $display("FAIL halted_idle_%0d: got %h, expected %h", i, dut_vec(), exp_vec);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 10'h1FF, 1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({HLT, halted} !== 2'b11) begin
      tests_failed++;
      $display("FAIL resume_pulse_cycle: got %b, expected 11", {HLT, halted});
    end
    drive(1'b0, 1'b1, mk(6'h3F, 10'h0), 10'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({HLT, halted, jump, address} !== {3'b001, 10'h200} || dut_vec() !== exp_vec) begin
      tests_failed++;
      $display("FAIL resume_jump: got %h, expected %h", dut_vec(), exp_vec);
    end
    drive(1'b0, 1'b1, mk(6'h10, 10'h123), 10'h200, 1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({HLT, halted, jump, address} !== {3'b001, 10'h123}) begin
      tests_failed++;
      $display("FAIL run_after_resume: got %h, expected %h", {HLT, halted, jump, address}, {3'b001, 10'h123});
    end
    idle(10'h123);
    tests_run++;
    if ({HLT, halted, jump} !== 3'b000) begin
      tests_failed++;
      $display("FAIL resume_in_run_ignored: got %b, expected 000", {HLT, halted, jump});
    end
  endtask

  task automatic test_reset_in_halt();
    drive(1'b1, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, mk(6'h13, 10'h040), 10'h010, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, mk(6'h13, 10'h080), 10'h041, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, mk(6'h14, 10'h0), 10'h081, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, mk(6'h13, 10'h080), 10'h042, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, mk(6'h3F, 10'h0), 10'h081, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10'h081);
    drive(1'b1, 1'b1, mk(6'h14, 10'h0), 10'h081, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({jump, bzero, bnegative, HLT, address} !== 14'h0 || dut_vec() !== exp_vec) begin
      tests_failed++;
      $display("FAIL reset_during_halt: got %h, expected %h", dut_vec(), exp_vec);
    end
    drive(1'b0, 1'b1, mk(6'h14, 10'h0), 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({halted, HLT, stack_err, jump} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL post_reset_ret: got %b, expected 0000", {halted, HLT, stack_err, jump});
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    int sel;
    drive(1'b1, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = 6'h10;
        2:       op = 6'h11;
        3:       op = 6'h12;
        4, 5:    op = 6'h13;
        6, 7:    op = 6'h14;
        8:       op = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
        default: op = 6'($urandom);
      endcase
      drive(1'($urandom_range(0, 80) == 0), 1'($urandom_range(0, 7) != 0),
            mk(op, 10'($urandom)), 10'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 4) == 0));
      tests_run++;
      if (dut_vec() !== exp_vec) begin
        tests_failed++;
        $display("FAIL random_%0d: got %h, expected %h", i, dut_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jmp();
    test_flags_bz();
    test_call_ret();
    test_overflow();
    test_halt();
    test_reset_in_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
- Producer side of the program-counter control interface. Decodes the fetched instruction word and drives jump, bzero, bnegative, address, HLT, zero and negative into the program counter.
- Owns the registered ALU condition flags, a 4-deep return-address stack (CALL/RET) and the halt/resume state machine.
- Sits between instruction memory/ALU and the PC, in the CPU datapath top level.

Parameters:
- ADDR_W, 10, instruction address width (matches the PC).
- INSTR_W, 32, instruction word width.
- STACK_DEPTH, 4, return-address stack entries (power of 2).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- resetCPU  in  1  synchronous, active-high reset.
- programCounter  in  ADDR_W  current PC value (address of the instruction on `instruction`).
- instruction  in  INSTR_W  instruction word at programCounter.
- instr_valid  in  1  instruction word is valid this cycle; when 0, the instruction decodes as NOP.
- alu_zero  in  1  ALU zero result.
- alu_negative  in  1  ALU negative result.
- flag_we  in  1  capture alu_zero/alu_negative into the flag registers.
- resume  in  1  single-cycle pulse that leaves HALT.
- jump  out  1  to PC: absolute jump to `address`.
- bzero  out  1  to PC: branch if zero.
- bnegative  out  1  to PC: branch if negative.
- address  out  ADDR_W  to PC: jump target or branch offset.
- zero  out  1  registered zero flag.
- negative  out  1  registered negative flag.
- HLT  out  1  to PC: hold programCounter.
- halted  out  1  state == HALT.
- stack_err  out  1  sticky overflow/underflow indicator.

Behaviour:
- Decode: opcode = instruction[31:26]; imm = instruction[9:0]. Opcodes:
  - JMP=6'h10
  - BZ=6'h11
  - BNEG=6'h12
  - CALL=6'h13
  - RET=6'h14
  - HLTOP=6'h3F
  - Any other opcode, or instr_valid=0, is a NOP for this block: all control outputs 0, address=0.
- Control outputs are combinational from instruction, state and stack. One active opcode at a time.
- States: RUN, HALT, RESUME. Reset goes to RUN.
- RUN:
  - JMP: jump=1, address=imm.
  - BZ: bzero=1, address=imm. Offset is relative to PC+1; the PC performs the add.
  - BNEG: bnegative=1, address=imm.
  - CALL: jump=1, address=imm; push programCounter+1 (mod 2^ADDR_W) at the clock edge.
  - RET: if stack is non-empty, jump=1, address=top, pop at the clock edge. If empty, no jump, set stack_err, execute as NOP.
  - HLTOP: HLT=1 combinationally; latch halt_pc=programCounter; next state HALT.
- HALT:
  - HLT=1, halted=1, all other control outputs 0; instruction is ignored.
  - resume=1 moves to RESUME at the next edge.
- RESUME: HLT=0, jump=1, address=halt_pc+1. Next state RUN. Execution continues after the halt instruction.
- resume in RUN or RESUME is ignored.
- Flags:
  - zero/negative update on the edge when flag_we=1; otherwise hold.
  - Flag updates are allowed in every state, including HALT.
  - A BZ in the same cycle as flag_we uses the old flag value (registered).
- Stack:
  - Push when full: push is dropped, stack_err=1, the jump still occurs.
  - Pop on empty: see RET above.
  - stack_err clears only on reset.
- Reset (at any time, including mid-HALT): state=RUN, stack empty, zero=0, negative=0, stack_err=0, halt_pc=0.
  - During the reset cycle all control outputs (jump, bzero, bnegative, HLT, address) are forced to 0.

Decomposition:
- Package pc_ctrl_pkg: opcode constants, state enum (RUN/HALT/RESUME), ADDR_W default.
- One sub-module: ret_addr_stack (LIFO with push/pop, full/empty flags, top output; simultaneous push+pop never occurs).

Test Plan:
- Reset then JMP imm=0x050 at PC=0x100 -> jump=1, address=0x050, no other control asserted.
- flag_we with alu_zero=1, next cycle BZ imm=0x004 -> zero=1, bzero=1, address=0x004. Same-cycle flag_we+BZ -> old zero value used.
- CALL 0x020 at PC=0x105, then RET at PC=0x022 -> first push 0x106; RET gives jump=1, address=0x106, stack empty afterward.
- Five CALLs with no RET -> fifth push dropped, stack_err=1; four RETs return the four stored addresses in LIFO order; a fifth RET gives no jump.
- HLTOP at PC=0x1FF -> HLT=1 that cycle and while halted, including with 10 idle cycles. resume pulse -> next cycle HLT=0, jump=1, address=0x200, then RUN.
- resetCPU asserted while in HALT with 2 stack entries -> next cycle halted=0, HLT=0, stack_err=0, RET causes no jump.
